// File: rtl/lights_zone_ctrl.sv
// Multi-room lighting controller: shared daylight hysteresis flag plus per-room OFF/ON/HOLD FSM with hold-off timer.
// Optional manual override (FORCED state, manual_on_i/manual_off_i ports) enabled by defining LIGHTS_MANUAL_EN.
module lights_zone_ctrl #(
    parameter int N_ROOMS     = 4,
    parameter int LIGHT_W     = 8,
    parameter int ON_THRESH   = 60,
    parameter int OFF_THRESH  = 80,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LIGHT_W-1:0] daylight_i,
    input  logic [N_ROOMS-1:0] presence_i,
`ifdef LIGHTS_MANUAL_EN
    input  logic [N_ROOMS-1:0] manual_on_i,
    input  logic [N_ROOMS-1:0] manual_off_i,
`endif
    output logic [N_ROOMS-1:0] lights_o,
    output logic               dark_o
);

    localparam int                 CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [LIGHT_W-1:0] ON_T      = LIGHT_W'(ON_THRESH);
    localparam logic [LIGHT_W-1:0] OFF_T     = LIGHT_W'(OFF_THRESH);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_HOLD
`ifdef LIGHTS_MANUAL_EN
        , ST_FORCED
`endif
    } room_state_e;

    logic dark_q, dark_d;

    // Inside the band between the two thresholds the flag keeps its previous value.
    always_comb begin
        dark_d = dark_q;
        if (daylight_i < ON_T) begin
            dark_d = 1'b1;
        end else if (daylight_i >= OFF_T) begin
            dark_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dark_q <= 1'b0;
        end else begin
            dark_q <= dark_d;
        end
    end

    assign dark_o = dark_q;

    for (genvar i = 0; i < N_ROOMS; i++) begin : g_room
        room_state_e      state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             light_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
`ifdef LIGHTS_MANUAL_EN
            if (manual_off_i[i]) begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end else if (manual_on_i[i]) begin
                state_d = ST_FORCED;
                cnt_d   = '0;
            end else
`endif
            begin
                case (state_q)
                    ST_OFF: begin
                        if (dark_q && presence_i[i]) state_d = ST_ON;
                    end
                    ST_ON: begin
                        if (!dark_q) begin
                            state_d = ST_OFF;
                        end else if (!presence_i[i]) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        // Bright beats presence, presence beats expiry.
                        if (!dark_q) begin
                            state_d = ST_OFF;
                            cnt_d   = '0;
                        end else if (presence_i[i]) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                        end else if (cnt_q == '0) begin
                            state_d = ST_OFF;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
`ifdef LIGHTS_MANUAL_EN
                    ST_FORCED: begin
                        state_d = ST_FORCED;
                    end
`endif
                    default: begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
                light_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                light_q <= (state_d != ST_OFF);
            end
        end

        assign lights_o[i] = light_q;
    end

endmodule

// File: tb/tb_lights_zone_ctrl.sv
// Bench for lights_zone_ctrl: reset, table of daylight/presence vectors, hand-written corner sequences,
// then random stimulus against an "age since last dark presence" model.
module tb_lights_zone_ctrl;

    localparam int N    = 4;
    localparam int HOLD = 5;
    localparam int INF  = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   daylight;
    logic [N-1:0] presence;
    logic [N-1:0] lights;
    logic         dark;
`ifdef LIGHTS_MANUAL_EN
    logic [N-1:0] manual_on;
    logic [N-1:0] manual_off;
`endif

    int n_total = 0;
    int n_pass  = 0;

    int age [N];
    bit dark_m;

    typedef struct packed {
        logic [7:0]   dl;
        logic [N-1:0] p;
        logic [N-1:0] l;
        logic         d;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    lights_zone_ctrl #(
        .N_ROOMS(N), .LIGHT_W(8), .ON_THRESH(60), .OFF_THRESH(80), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .daylight_i(daylight),
        .presence_i(presence),
`ifdef LIGHTS_MANUAL_EN
        .manual_on_i(manual_on),
        .manual_off_i(manual_off),
`endif
        .lights_o(lights),
        .dark_o(dark)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // A room is lit while fewer than HOLD+1 edges have passed since it last saw presence with dark set;
    // any edge seen while not dark ends the episode.
    task automatic model_edge();
        bit nd;
        nd = (daylight < 60) ? 1'b1 : (daylight >= 80) ? 1'b0 : dark_m;
        for (int r = 0; r < N; r++) begin
            if (!dark_m)          age[r] = INF;
            else if (presence[r]) age[r] = 0;
            else if (age[r] < INF) age[r] = age[r] + 1;
        end
        dark_m = nd;
    endtask

    function automatic logic [N-1:0] model_lights();
        logic [N-1:0] v;
        for (int r = 0; r < N; r++) v[r] = (age[r] <= HOLD);
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < N; r++) age[r] = INF;
        dark_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{8'd50, 4'h0, 4'h0, 1'b1};
        tbl[1]  = '{8'd70, 4'h1, 4'h1, 1'b1};
        tbl[2]  = '{8'd70, 4'h0, 4'h1, 1'b1};
        tbl[3]  = '{8'd70, 4'h0, 4'h1, 1'b1};
        tbl[4]  = '{8'd70, 4'h0, 4'h1, 1'b1};
        tbl[5]  = '{8'd70, 4'h0, 4'h1, 1'b1};
        tbl[6]  = '{8'd70, 4'h0, 4'h1, 1'b1};
        tbl[7]  = '{8'd70, 4'h0, 4'h0, 1'b1};
        tbl[8]  = '{8'd90, 4'h0, 4'h0, 1'b0};
        tbl[9]  = '{8'd70, 4'h2, 4'h0, 1'b0};
        tbl[10] = '{8'd50, 4'h2, 4'h0, 1'b1};
        tbl[11] = '{8'd50, 4'h2, 4'h2, 1'b1};
        tbl[12] = '{8'd90, 4'h2, 4'h2, 1'b0};
        tbl[13] = '{8'd90, 4'h2, 4'h0, 1'b0};

        model_reset();
        rst_n    = 1'b0;
        daylight = 8'd0;
        presence = 4'hF;
`ifdef LIGHTS_MANUAL_EN
        manual_on  = '0;
        manual_off = '0;
`endif
        // Reset held across clock edges with dark-and-presence inputs active.
        repeat (3) @(negedge clk);
        check("rst_lights", lights, 4'h0);
        check("rst_dark", dark, 1'b0);
        rst_n = 1'b1;
        tick();
        check("rel_dark_1clk", dark, 1'b1);
        check("rel_lights_1clk", lights, 4'h0);
        tick();
        check("rel_lights_2clk", lights, 4'hF);

        // Return to a bright idle state before the table.
        presence = 4'h0;
        daylight = 8'd200;
        repeat (HOLD + 3) tick();
        check("idle_lights", lights, 4'h0);
        check("idle_dark", dark, 1'b0);

        for (int k = 0; k < 14; k++) begin
            daylight = tbl[k].dl;
            presence = tbl[k].p;
            tick();
            check($sformatf("tbl%0d_lights", k), lights, tbl[k].l);
            check($sformatf("tbl%0d_dark", k), dark, tbl[k].d);
        end

        // Presence arriving exactly at expiry keeps the light on; then bright turns it off 2 clk later.
        daylight = 8'd50;
        presence = 4'h8;
        tick();
        tick();
        presence = 4'h0;
        for (int k = 0; k < HOLD; k++) begin
            tick();
            check($sformatf("hold_on%0d", k), lights[3], 1'b1);
        end
        presence = 4'h8;
        tick();
        check("expiry_vs_presence", lights[3], 1'b1);
        presence = 4'h0;
        tick();
        check("hold_again", lights[3], 1'b1);
        daylight = 8'd90;
        tick();
        check("bright_hold_1clk", lights[3], 1'b1);
        check("bright_dark_1clk", dark, 1'b0);
        tick();
        check("bright_hold_2clk", lights[3], 1'b0);

        // Asynchronous reset in the middle of a hold count.
        daylight = 8'd50;
        tick();
        presence = 4'h4;
        tick();
        presence = 4'h0;
        tick();
        tick();
        check("pre_rst_hold", lights, 4'h4);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_lights", lights, 4'h0);
        check("async_rst_dark", dark, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post_rst_off%0d", k), lights, 4'h0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            daylight = 8'($urandom_range(40, 100));
            if ($urandom_range(0, 3) == 0) presence = N'($urandom);
            tick();
            check("rnd_lights", lights, model_lights());
            check("rnd_dark", dark, dark_m);
        end

`ifdef LIGHTS_MANUAL_EN
        daylight = 8'd200;
        presence = 4'h0;
        repeat (HOLD + 3) tick();
        manual_on = 4'h4;
        tick();
        manual_on = 4'h0;
        check("man_on_1clk", lights, 4'h4);
        for (int k = 0; k < 20; k++) begin
            presence = N'($urandom);
            tick();
            check("man_forced_hold", lights[2], 1'b1);
        end
        presence   = 4'h0;
        manual_on  = 4'h4;
        manual_off = 4'h4;
        tick();
        manual_on  = 4'h0;
        manual_off = 4'h0;
        check("man_both_off", lights, 4'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
